flood_move_ctrl: RTL and testbench

Move sequencer for the Flood-It board memory. It sits between the game-mode input logic and the single-port board RAM. On each accepted colour move it recolours the flooded region and grows it through same-colour neighbours. It then counts tries and reports win or lose against the tries budget computed by the selection logic.

---
 rtl/flood_move_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 tb/tb_flood_move_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flood_move_ctrl.sv
// ---------------------------------------------------------------------------
// flood_move_ctrl
//
// Move sequencer for the Flood-It board memory. Accepts a colour move,
// recolours the flooded region and grows it through same-colour neighbours
// by repeated raster passes over the single-port board RAM, then updates
// the tries counter and the sticky win/lose flags.
//
// RAM word layout : {FLOOD, COLOR[2:0]}
// RAM address     : {row[4:0], col[4:0]}
//
// Ports
//   MASTER_CLOCK  in   sole clock
//   RESET         in   synchronous active-high reset
//   NEW_GAME      in   pulse: clear TRIES/WIN/LOSE, abort any move
//   SIZE          in   board edge (2..26), stable while BUSY
//   COLOR_NUM     in   number of colours in play (3..8)
//   TOTAL_TRIES   in   tries budget
//   MOVE_REQ      in   move request level, sampled in IDLE only
//   MOVE_COLOR    in   requested colour
//   MOVE_ACK      out  pulse: move accepted
//   MOVE_REJ      out  pulse: move rejected
//   BUSY          out  move in progress (acceptance .. DONE)
//   DONE          out  pulse: move applied, TRIES/WIN/LOSE valid
//   TRIES         out  accepted moves this game (saturating)
//   WIN / LOSE    out  sticky game result flags
//   MEM_ADDR      out  RAM address
//   MEM_RDATA     in   RAM read data, one cycle after MEM_ADDR
//   MEM_WE        out  RAM write strobe
//   MEM_WDATA     out  RAM write data
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | wait for MOVE_REQ
// CHK_RD    | address corner cell (0,0)
// CHK_WAIT  | corner data valid, accept/reject decision
// CELL_RD   | address current scan cell
// CELL_WAIT | cell data valid, classify cell
// NB_RD     | address current neighbour
// NB_WAIT   | neighbour data valid, stop on first flooded neighbour
// CELL_WR   | write {1,C} to current cell
// NEXT      | advance raster position
// PASS_END  | rescan if the pass grew the region, otherwise finish
// FINISH    | update WIN/LOSE, pulse DONE
// ---------------------------------------------------------------------------
module flood_move_ctrl #(
    parameter int ADDR_W = 10,
    parameter int CELL_W = 4
) (
    input  logic              MASTER_CLOCK,
    input  logic              RESET,
    input  logic              NEW_GAME,
    input  logic [4:0]        SIZE,
    input  logic [3:0]        COLOR_NUM,
    input  logic [7:0]        TOTAL_TRIES,
    input  logic              MOVE_REQ,
    input  logic [2:0]        MOVE_COLOR,
    output logic              MOVE_ACK,
    output logic              MOVE_REJ,
    output logic              BUSY,
    output logic              DONE,
    output logic [7:0]        TRIES,
    output logic              WIN,
    output logic              LOSE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [CELL_W-1:0] MEM_RDATA,
    output logic              MEM_WE,
    output logic [CELL_W-1:0] MEM_WDATA
);

    typedef enum logic [3:0] {
        IDLE,
        CHK_RD,
        CHK_WAIT,
        CELL_RD,
        CELL_WAIT,
        NB_RD,
        NB_WAIT,
        CELL_WR,
        NEXT,
        PASS_END,
        FINISH
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [4:0]  r_row;
    logic [4:0]  r_col;
    logic [1:0]  r_nb;
    logic [2:0]  r_color;
    logic [9:0]  r_cnt;
    logic        r_changed;
    logic [7:0]  r_tries;
    logic        r_win;
    logic        r_lose;
    logic        r_ack;
    logic        r_rej;
    logic        r_done;
    logic        r_busy;

    logic [4:0]  w_last;
    logic [3:0]  w_nb_ok;
    logic [2:0]  w_nb_first;
    logic [2:0]  w_nb_after;
    logic [4:0]  w_nb_row;
    logic [4:0]  w_nb_col;
    logic        w_rd_flood;
    logic [2:0]  w_rd_color;
    logic [9:0]  w_area;
    logic        w_win;
    logic        w_bad_color;

    logic        w_latch_color;
    logic        w_accept;
    logic        w_reject;
    logic        w_cnt_inc;
    logic        w_mark_new;
    logic        w_nb_load;
    logic [1:0]  w_nb_sel;
    logic        w_step;
    logic        w_new_pass;
    logic        w_finish;
    logic [ADDR_W-1:0] w_mem_addr;
    logic        w_mem_we;
    logic [CELL_W-1:0] w_mem_wdata;

    // First in-board neighbour at or after 'start'; bit 2 flags a hit.
    // Neighbour order: 0 up, 1 down, 2 left, 3 right.
    function automatic logic [2:0] pick_nb(input logic [3:0] ok, input logic [2:0] start);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if ((i >= int'(start)) && ok[i]) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

    assign w_last      = SIZE - 5'd1;
    assign w_nb_ok     = {(r_col != w_last), (r_col != 5'd0), (r_row != w_last), (r_row != 5'd0)};
    assign w_nb_first  = pick_nb(w_nb_ok, 3'd0);
    assign w_nb_after  = pick_nb(w_nb_ok, {1'b0, r_nb} + 3'd1);
    assign w_rd_flood  = MEM_RDATA[CELL_W-1];
    assign w_rd_color  = MEM_RDATA[2:0];
    assign w_area      = {5'd0, SIZE} * {5'd0, SIZE};
    assign w_win       = (r_cnt == w_area);
    assign w_bad_color = ({1'b0, r_color} >= COLOR_NUM);

    always_comb begin
        w_nb_row = r_row;
        w_nb_col = r_col;
        case (r_nb)
            2'd0:    w_nb_row = r_row - 5'd1;
            2'd1:    w_nb_row = r_row + 5'd1;
            2'd2:    w_nb_col = r_col - 5'd1;
            default: w_nb_col = r_col + 5'd1;
        endcase
    end

    always_comb begin
        w_mem_wdata           = '0;
        w_mem_wdata[CELL_W-1] = 1'b1;
        w_mem_wdata[2:0]      = r_color;
    end

    always_comb begin
        w_next        = r_state;
        w_latch_color = 1'b0;
        w_accept      = 1'b0;
        w_reject      = 1'b0;
        w_cnt_inc     = 1'b0;
        w_mark_new    = 1'b0;
        w_nb_load     = 1'b0;
        w_nb_sel      = r_nb;
        w_step        = 1'b0;
        w_new_pass    = 1'b0;
        w_finish      = 1'b0;
        w_mem_addr    = '0;
        w_mem_we      = 1'b0;

        case (r_state)
            IDLE: begin
                if (MOVE_REQ) begin
                    w_latch_color = 1'b1;
                    w_next        = CHK_RD;
                end
            end

            CHK_RD: begin
                w_mem_addr = '0;
                w_next     = CHK_WAIT;
            end

            CHK_WAIT: begin
                // All reject causes resolve here so ACK and REJ share one latency.
                if (w_bad_color || r_win || r_lose || (w_rd_color == r_color)) begin
                    w_reject = 1'b1;
                    w_next   = IDLE;
                end else begin
                    w_accept = 1'b1;
                    w_next   = CELL_RD;
                end
            end

            CELL_RD: begin
                w_mem_addr = ADDR_W'({r_row, r_col});
                w_next     = CELL_WAIT;
            end

            CELL_WAIT: begin
                if (w_rd_flood) begin
                    w_cnt_inc = 1'b1;
                    w_next    = (w_rd_color != r_color) ? CELL_WR : NEXT;
                end else if ((w_rd_color == r_color) && w_nb_first[2]) begin
                    w_nb_load = 1'b1;
                    w_nb_sel  = w_nb_first[1:0];
                    w_next    = NB_RD;
                end else begin
                    w_next = NEXT;
                end
            end

            NB_RD: begin
                w_mem_addr = ADDR_W'({w_nb_row, w_nb_col});
                w_next     = NB_WAIT;
            end

            NB_WAIT: begin
                if (w_rd_flood) begin
                    w_cnt_inc  = 1'b1;
                    w_mark_new = 1'b1;
                    w_next     = CELL_WR;
                end else if (w_nb_after[2]) begin
                    w_nb_load = 1'b1;
                    w_nb_sel  = w_nb_after[1:0];
                    w_next    = NB_RD;
                end else begin
                    w_next = NEXT;
                end
            end

            CELL_WR: begin
                w_mem_addr = ADDR_W'({r_row, r_col});
                w_mem_we   = 1'b1;
                w_next     = NEXT;
            end

            NEXT: begin
                w_step = 1'b1;
                if ((r_col == w_last) && (r_row == w_last)) begin
                    w_next = PASS_END;
                end else begin
                    w_next = CELL_RD;
                end
            end

            PASS_END: begin
                if (r_changed) begin
                    w_new_pass = 1'b1;
                    w_next     = CELL_RD;
                end else begin
                    w_next = FINISH;
                end
            end

            FINISH: begin
                w_finish = 1'b1;
                w_next   = IDLE;
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge MASTER_CLOCK) begin
        if (RESET || NEW_GAME) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_nb      <= '0;
            r_color   <= '0;
            r_cnt     <= '0;
            r_changed <= 1'b0;
            r_tries   <= '0;
            r_win     <= 1'b0;
            r_lose    <= 1'b0;
            r_ack     <= 1'b0;
            r_rej     <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_accept;
            r_rej   <= w_reject;
            r_done  <= w_finish;

            if (w_latch_color) begin
                r_color <= MOVE_COLOR;
            end

            if (w_accept) begin
                r_busy    <= 1'b1;
                r_tries   <= (r_tries == 8'hFF) ? r_tries : r_tries + 8'd1;
                r_row     <= '0;
                r_col     <= '0;
                r_cnt     <= '0;
                r_changed <= 1'b0;
            end

            if (w_cnt_inc) begin
                r_cnt <= r_cnt + 10'd1;
            end

            if (w_mark_new) begin
                r_changed <= 1'b1;
            end

            if (w_nb_load) begin
                r_nb <= w_nb_sel;
            end

            if (w_step) begin
                if (r_col == w_last) begin
                    r_col <= '0;
                    r_row <= (r_row == w_last) ? 5'd0 : r_row + 5'd1;
                end else begin
                    r_col <= r_col + 5'd1;
                end
            end

            if (w_new_pass) begin
                r_changed <= 1'b0;
                r_cnt     <= '0;
            end

            if (w_finish) begin
                r_win  <= w_win;
                r_lose <= !w_win && (r_tries == TOTAL_TRIES);
                r_busy <= 1'b0;
            end
        end
    end

    assign MOVE_ACK  = r_ack;
    assign MOVE_REJ  = r_rej;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign TRIES     = r_tries;
    assign WIN       = r_win;
    assign LOSE      = r_lose;
    assign MEM_ADDR  = w_mem_addr;
    assign MEM_WE    = w_mem_we;
    assign MEM_WDATA = w_mem_wdata;

endmodule

// File: tb/tb_flood_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_flood_move_ctrl
//
// Bench for flood_move_ctrl: behavioural board RAM with registered read,
// a worklist flood-fill reference of the board, a table of move vectors
// and hand sequences for NEW_GAME / RESET aborts.
// ---------------------------------------------------------------------------
module tb_flood_move_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       RESET;
    logic       NEW_GAME;
    logic [4:0] SIZE;
    logic [3:0] COLOR_NUM;
    logic [7:0] TOTAL_TRIES;
    logic       MOVE_REQ;
    logic [2:0] MOVE_COLOR;
    logic       MOVE_ACK;
    logic       MOVE_REJ;
    logic       BUSY;
    logic       DONE;
    logic [7:0] TRIES;
    logic       WIN;
    logic       LOSE;
    logic [9:0] MEM_ADDR;
    logic [3:0] MEM_RDATA;
    logic       MEM_WE;
    logic [3:0] MEM_WDATA;

    flood_move_ctrl #(.ADDR_W(10), .CELL_W(4)) dut (
        .MASTER_CLOCK (clk),
        .RESET        (RESET),
        .NEW_GAME     (NEW_GAME),
        .SIZE         (SIZE),
        .COLOR_NUM    (COLOR_NUM),
        .TOTAL_TRIES  (TOTAL_TRIES),
        .MOVE_REQ     (MOVE_REQ),
        .MOVE_COLOR   (MOVE_COLOR),
        .MOVE_ACK     (MOVE_ACK),
        .MOVE_REJ     (MOVE_REJ),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .TRIES        (TRIES),
        .WIN          (WIN),
        .LOSE         (LOSE),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_RDATA    (MEM_RDATA),
        .MEM_WE       (MEM_WE),
        .MEM_WDATA    (MEM_WDATA)
    );

    // Board RAM; the load port stands in for the board initializer.
    logic [3:0] mem   [0:1023];
    logic [3:0] model [0:1023];
    logic       ld_we;
    logic [9:0] ld_addr;
    logic [3:0] ld_data;

    always @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
        else if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
        MEM_RDATA <= mem[MEM_ADDR];
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int board;      // 0 = keep current game and board
        int size;
        int cn;
        int tt;
        int mc;
        bit exp_ack;
        int exp_tries;
        bit exp_win;
        bit exp_lose;
        int exp_cyc;    // cycles from ACK to DONE, -1 = not checked
        bit chk_gap;    // check the final pass is write-free
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] addr_of(input int r, input int c);
        return {5'(r), 5'(c)};
    endfunction

    task automatic cell_set(input int r, input int c, input logic [3:0] val);
        model[addr_of(r, c)] = val;
        ld_we   = 1'b1;
        ld_addr = addr_of(r, c);
        ld_data = val;
        tick();
        ld_we   = 1'b0;
    endtask

    task automatic load_board(input int id, input int n);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                logic [3:0] v;
                v = 4'd0;
                if (id == 1) begin
                    if (r == 0 && c == 0) v = 4'b1001;
                    else if (r == 1 && c == 1) v = 4'd0;
                    else v = 4'd2;
                end else if (id == 2) begin
                    if (r == 0 && c == 0) v = 4'b1000;
                    else v = 4'((r + 2 * c) % 3);
                end else begin
                    v = 4'd2;
                    if (r == 0 && c > 0) v = 4'd1;
                    if (r == 1 && c == 5) v = 4'd1;
                    if (r == 2) v = 4'd1;
                    if (r == 3 && c == 0) v = 4'd1;
                    if (r == 4) v = 4'd1;
                    if (r == 0 && c == 0) v = 4'b1000;
                end
                cell_set(r, c, v);
            end
        end
    endtask

    // Reference: recolour the region, then worklist growth through colour c.
    task automatic ref_move(input int c, input int n);
        int q[$];
        for (int r = 0; r < n; r++)
            for (int k = 0; k < n; k++)
                if (model[addr_of(r, k)][3]) begin
                    model[addr_of(r, k)] = {1'b1, 3'(c)};
                    q.push_back(r * 32 + k);
                end
        while (q.size() > 0) begin
            int a, r, k;
            a = q.pop_front();
            r = a / 32;
            k = a % 32;
            for (int d = 0; d < 4; d++) begin
                int nr, nk;
                nr = r + ((d == 0) ? -1 : (d == 1) ? 1 : 0);
                nk = k + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
                if (nr >= 0 && nr < n && nk >= 0 && nk < n) begin
                    if (!model[addr_of(nr, nk)][3] && model[addr_of(nr, nk)][2:0] == 3'(c)) begin
                        model[addr_of(nr, nk)] = {1'b1, 3'(c)};
                        q.push_back(nr * 32 + nk);
                    end
                end
            end
        end
    endtask

    task automatic check_ram(input string name, input int n);
        int bad;
        bad = 0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                if (mem[addr_of(r, c)] !== model[addr_of(r, c)]) bad++;
        check(name, bad, 0);
    endtask

    task automatic pulse_new_game();
        NEW_GAME = 1'b1;
        tick();
        NEW_GAME = 1'b0;
        tick();
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int  lat, m, last_we, extra, dones, wes;
        bit  got;
        bit  acked;
        lat = 0; m = 0; last_we = 0; extra = 0; dones = 0; wes = 0; got = 0; acked = 0;
        if (v.board != 0) begin
            SIZE        = 5'(v.size);
            COLOR_NUM   = 4'(v.cn);
            TOTAL_TRIES = 8'(v.tt);
            pulse_new_game();
            load_board(v.board, v.size);
        end
        MOVE_COLOR = 3'(v.mc);
        MOVE_REQ   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            lat++;
            if (MEM_WE) wes++;
            if (MOVE_ACK || MOVE_REJ) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            MOVE_REQ = 1'b0;
            check($sformatf("v%0d response timeout", i), 0, 1);
            return;
        end
        check($sformatf("v%0d response latency", i), lat, 3);
        acked = MOVE_ACK;
        check($sformatf("v%0d ack", i), int'(MOVE_ACK), int'(v.exp_ack));
        check($sformatf("v%0d rej", i), int'(MOVE_REJ), int'(!v.exp_ack));
        if (acked) begin
            check($sformatf("v%0d busy at ack", i), int'(BUSY), 1);
            got = 1'b0;
            for (int k = 0; k < 20000; k++) begin
                tick();
                m++;
                if (m == 10) MOVE_REQ = 1'b0;
                if (MOVE_ACK || MOVE_REJ) extra++;
                if (MEM_WE) last_we = m;
                if (DONE) begin
                    got = 1'b1;
                    break;
                end
            end
            MOVE_REQ = 1'b0;
            if (!got) begin
                check($sformatf("v%0d done timeout", i), 0, 1);
                return;
            end
            dones = 1;
            check($sformatf("v%0d busy at done", i), int'(BUSY), 0);
            check($sformatf("v%0d tries", i), int'(TRIES), v.exp_tries);
            check($sformatf("v%0d win", i), int'(WIN), int'(v.exp_win));
            check($sformatf("v%0d lose", i), int'(LOSE), int'(v.exp_lose));
            check($sformatf("v%0d req ignored while busy", i), extra, 0);
            if (v.exp_cyc >= 0) check($sformatf("v%0d ack-to-done cycles", i), m, v.exp_cyc);
            if (v.chk_gap) begin
                check($sformatf("v%0d last pass write-free", i),
                      int'((m - last_we) >= 3 * v.size * v.size + 5), 1);
                check($sformatf("v%0d multiple passes", i),
                      int'(m >= 6 * 3 * v.size * v.size), 1);
            end
        end else begin
            MOVE_REQ = 1'b0;
            check($sformatf("v%0d tries after rej", i), int'(TRIES), v.exp_tries);
            check($sformatf("v%0d win after rej", i), int'(WIN), int'(v.exp_win));
            check($sformatf("v%0d lose after rej", i), int'(LOSE), int'(v.exp_lose));
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            if (DONE) dones++;
            if (MEM_WE) wes++;
        end
        check($sformatf("v%0d done pulses", i), dones, acked ? 1 : 0);
        if (!acked) check($sformatf("v%0d no writes on rej", i), wes, 0);
        if (v.exp_ack) ref_move(v.mc, v.size);
        check_ram($sformatf("v%0d ram", i), v.size);
    endtask

    task automatic abort_test(input bit use_reset);
        string tag;
        int    bad;
        bit    got;
        tag = use_reset ? "reset" : "new_game";
        bad = 0;
        got = 1'b0;
        SIZE        = 5'd6;
        COLOR_NUM   = 4'd3;
        TOTAL_TRIES = 8'd8;
        pulse_new_game();
        load_board(3, 6);
        MOVE_COLOR = 3'd1;
        MOVE_REQ   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (MOVE_ACK) begin
                got = 1'b1;
                break;
            end
        end
        MOVE_REQ = 1'b0;
        check({tag, " abort ack"}, int'(got), 1);
        repeat (40) tick();
        check({tag, " busy before abort"}, int'(BUSY), 1);
        check({tag, " tries before abort"}, int'(TRIES), 1);
        if (use_reset) RESET = 1'b1;
        else NEW_GAME = 1'b1;
        tick();
        RESET    = 1'b0;
        NEW_GAME = 1'b0;
        check({tag, " busy after abort"}, int'(BUSY), 0);
        check({tag, " tries after abort"}, int'(TRIES), 0);
        check({tag, " we after abort"}, int'(MEM_WE), 0);
        check({tag, " done after abort"}, int'(DONE), 0);
        check({tag, " flags after abort"}, int'({WIN, LOSE}), 0);
        for (int k = 0; k < 300; k++) begin
            tick();
            if (DONE || MEM_WE || BUSY || MOVE_ACK || MOVE_REJ) bad++;
        end
        check({tag, " quiet after abort"}, bad, 0);
    endtask

    initial begin
        RESET       = 1'b1;
        NEW_GAME    = 1'b0;
        SIZE        = 5'd2;
        COLOR_NUM   = 4'd3;
        TOTAL_TRIES = 8'd2;
        MOVE_REQ    = 1'b0;
        MOVE_COLOR  = 3'd0;
        ld_we       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;

        //          board size cn tt mc ack tries win lose cyc gap
        vecs[0] = '{1, 2, 3, 2, 1, 1'b0, 0, 1'b0, 1'b0, -1, 1'b0};
        vecs[1] = '{0, 2, 3, 2, 5, 1'b0, 0, 1'b0, 1'b0, -1, 1'b0};
        vecs[2] = '{0, 2, 3, 2, 3, 1'b0, 0, 1'b0, 1'b0, -1, 1'b0};
        vecs[3] = '{0, 2, 3, 2, 2, 1'b1, 1, 1'b0, 1'b0, 36, 1'b0};
        vecs[4] = '{0, 2, 3, 2, 0, 1'b1, 2, 1'b1, 1'b0, 33, 1'b0};
        vecs[5] = '{0, 2, 3, 2, 1, 1'b0, 2, 1'b1, 1'b0, -1, 1'b0};
        vecs[6] = '{2, 6, 3, 1, 1, 1'b1, 1, 1'b0, 1'b1, -1, 1'b0};
        vecs[7] = '{0, 6, 3, 1, 2, 1'b0, 1, 1'b0, 1'b1, -1, 1'b0};
        vecs[8] = '{3, 6, 3, 8, 1, 1'b1, 1, 1'b0, 1'b0, -1, 1'b1};
        vecs[9] = '{0, 6, 3, 8, 2, 1'b1, 2, 1'b1, 1'b0, -1, 1'b0};

        repeat (3) tick();
        RESET = 1'b0;
        check("reset pulses", int'({MOVE_ACK, MOVE_REJ, BUSY, DONE}), 0);
        check("reset tries", int'(TRIES), 0);
        check("reset flags", int'({WIN, LOSE}), 0);
        check("reset mem_addr", int'(MEM_ADDR), 0);
        check("reset mem_we", int'(MEM_WE), 0);

        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        abort_test(1'b0);
        abort_test(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
